// File: rtl/seu_log_pkg.sv
// Shared constants and record layout for the SEU event logger.
package seu_log_pkg;

  localparam int ERRW_DEF = 2;   // bit 0 = pipeline voters, bit 1 = SEU-counter voters
  localparam int TSW_DEF  = 16;  // timestamp width
  localparam int REC_W    = ERRW_DEF + TSW_DEF;

  // One logged event: which voter groups rose, and when.
  typedef struct packed {
    logic [ERRW_DEF-1:0] src;
    logic [TSW_DEF-1:0]  stamp;
  } seu_rec_t;

endpackage

// File: rtl/seu_event_logger_if.sv
// Readout handshake between the logger (master) and the draining consumer.
// Valid/ready: a record transfers on a rising clk edge where evValid && evReady.
// evSrc/evTime are meaningful only while evValid is high, and stay stable until
// that transfer. evValid never depends combinationally on evReady.
interface seu_event_logger_if
  import seu_log_pkg::*;
#(
  parameter int ERRW = ERRW_DEF,
  parameter int TSW  = TSW_DEF
) ();

  logic            evValid;
  logic            evReady;
  logic [ERRW-1:0] evSrc;
  logic [TSW-1:0]  evTime;

  modport master (output evValid, output evSrc, output evTime, input evReady);
  modport slave  (input evValid, input evSrc, input evTime, output evReady);

endinterface

// File: rtl/seu_log_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module seu_log_fifo
  import seu_log_pkg::*;
#(
  parameter int W     = REC_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     push_ok_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q, fill_q;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full (lap differs) from empty (lap equal).
  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      fill_q <= fill_q + 1'b1;
      else if (do_pop && !do_push) fill_q <= fill_q - 1'b1;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o    = mem_q[rd_q[AW-1:0]];
  assign push_ok_o = do_push;
  assign fill_o    = fill_q;

endmodule

// File: rtl/seu_event_logger.sv
// Timestamps rising edges of the TMR voter error flags and queues them for readout.
module seu_event_logger
  import seu_log_pkg::*;
#(
  parameter int ERRW  = ERRW_DEF,
  parameter int TSW   = TSW_DEF,
  parameter int DEPTH = 8,
  parameter int DROPW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ERRW-1:0]        errIn,
  seu_event_logger_if.master     ev,
  output logic [$clog2(DEPTH):0] fillLevel,
  output logic [DROPW-1:0]       dropCount,
  input  logic                   dropClr
);

  localparam int RW = ERRW + TSW;
  localparam logic [DROPW-1:0] DROP_MAX = '1;

  logic [TSW-1:0]   ts_q, ts_d;
  logic [ERRW-1:0]  err_prev_q;
  logic [DROPW-1:0] drop_q, drop_d;
  logic [ERRW-1:0]  rise;
  logic             ev_hit, push_ok, fifo_empty, fifo_full;
  logic [RW-1:0]    rec_in, rec_out;

  // Edge detect and next-state for timestamp and drop counter.
  always_comb begin
    rise   = errIn & ~err_prev_q;
    ev_hit = |rise;
    rec_in = {rise, ts_q};
    ts_d   = ts_q + TSW'(1);
    drop_d = drop_q;
    if (dropClr)                                  drop_d = '0;
    else if (ev_hit && !push_ok && drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
  end

  // State registers; reset clears everything so no event can form in a reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      err_prev_q <= '0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      err_prev_q <= errIn;
      drop_q     <= drop_d;
    end
  end

  seu_log_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (ev_hit),
    .din_i     (rec_in),
    .pop_i     (ev.evReady),
    .dout_o    (rec_out),
    .push_ok_o (push_ok),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .fill_o    (fillLevel)
  );

  assign ev.evValid = !fifo_empty;
  assign ev.evSrc   = rec_out[RW-1:TSW];
  assign ev.evTime  = rec_out[TSW-1:0];
  assign dropCount  = drop_q;

  // Full flag is implied by push_ok; kept visible for debug probing.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_seu_event_logger.sv
// Directed bench: one 16-bit-timestamp logger and one 4-bit-timestamp logger for wrap.
module tb_seu_event_logger;
  import seu_log_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (TSW = 16)
  logic        rst = 1'b1, dclr = 1'b0;
  logic [1:0]  err = '0;
  logic [3:0]  fill;
  logic [7:0]  drop;
  seu_event_logger_if #(.ERRW(2), .TSW(16)) ev_if ();

  seu_event_logger #(.ERRW(2), .TSW(16), .DEPTH(8), .DROPW(8)) u_dut (
    .clk(clk), .rst(rst), .errIn(err), .ev(ev_if),
    .fillLevel(fill), .dropCount(drop), .dropClr(dclr)
  );

  // Wrap instance (TSW = 4)
  logic        rst4 = 1'b1, dclr4 = 1'b0;
  logic [1:0]  err4 = '0;
  logic [3:0]  fill4;
  logic [7:0]  drop4;
  seu_event_logger_if #(.ERRW(2), .TSW(4)) ev4_if ();

  seu_event_logger #(.ERRW(2), .TSW(4), .DEPTH(8), .DROPW(8)) u_dut4 (
    .clk(clk), .rst(rst4), .errIn(err4), .ev(ev4_if),
    .fillLevel(fill4), .dropCount(drop4), .dropClr(dclr4)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [1:0] src, input logic [15:0] t);
    check({tag, "_valid"}, 32'(ev_if.evValid), 32'd1);
    check({tag, "_src"},   32'(ev_if.evSrc),   32'(src));
    check({tag, "_time"},  32'(ev_if.evTime),  32'(t));
  endtask

  initial begin
    seu_rec_t r;
    ev_if.evReady  = 1'b0;
    ev4_if.evReady = 1'b0;

    // 1: reset exit, idle for 10 cycles
    do_reset();
    check("rst_valid", 32'(ev_if.evValid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", 32'(ev_if.evValid), 32'd0);
      check("idle_fill",  32'(fill),          32'd0);
      check("idle_drop",  32'(drop),          32'd0);
    end

    // 2: single event held high for 20 cycles
    do_reset();
    repeat (5) step();
    err = 2'b01;
    step();
    check_head("single", 2'b01, 16'd5);
    check("single_fill", 32'(fill), 32'd1);
    repeat (19) step();
    check_head("hold", 2'b01, 16'd5);
    check("hold_fill", 32'(fill), 32'd1);
    err = 2'b00;
    ev_if.evReady = 1'b1;
    step();
    ev_if.evReady = 1'b0;
    check("single_pop_valid", 32'(ev_if.evValid), 32'd0);
    check("single_pop_fill",  32'(fill),          32'd0);

    // 3: simultaneous bits, then bit 1 alone, read in order
    do_reset();
    repeat (3) step();
    err = 2'b11;
    step();
    err = 2'b01;
    repeat (3) step();
    err = 2'b11;
    step();
    check("order_fill", 32'(fill), 32'd2);
    check_head("order0", 2'b11, 16'd3);
    ev_if.evReady = 1'b1;
    step();
    check_head("order1", 2'b10, 16'd7);
    check("order1_fill", 32'(fill), 32'd1);
    step();
    ev_if.evReady = 1'b0;
    check("order_empty", 32'(ev_if.evValid), 32'd0);
    err = 2'b00;

    // 4: overflow with 300 rising edges, drop counter saturates
    do_reset();
    for (int i = 0; i < 300; i++) begin
      err = 2'b01;
      step();
      err = 2'b00;
      step();
      if (i < 8) exp_q.push_back({2'b01, 16'(2 * i)});
      if (i == 19) check("drop_mid", 32'(drop), 32'd12);
    end
    check("ovf_fill", 32'(fill), 32'd8);
    check("ovf_drop", 32'(drop), 32'd255);
    check_head("ovf_head", 2'b01, 16'd0);
    // clear wins over a same-cycle drop (event at ts 600)
    err  = 2'b01;
    dclr = 1'b1;
    step();
    dclr = 1'b0;
    err  = 2'b00;
    check("clr_drop", 32'(drop), 32'd0);
    check("clr_fill", 32'(fill), 32'd8);
    step();

    // 5: full FIFO, push and pop together at ts 602
    err = 2'b10;
    ev_if.evReady = 1'b1;
    step();
    ev_if.evReady = 1'b0;
    err = 2'b00;
    void'(exp_q.pop_front());
    exp_q.push_back({2'b10, 16'd602});
    check("fullpp_fill", 32'(fill), 32'd8);
    check("fullpp_drop", 32'(drop), 32'd0);
    ev_if.evReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = seu_rec_t'(exp_q.pop_front());
      check_head("drain", r.src, r.stamp);
      step();
    end
    ev_if.evReady = 1'b0;
    check("drain_valid", 32'(ev_if.evValid), 32'd0);
    check("drain_fill",  32'(fill),          32'd0);

    // 6: timestamp wrap and mid-run reset on the 4-bit instance
    rst4 = 1'b1;
    repeat (3) step();
    rst4 = 1'b0;
    repeat (15) step();
    err4 = 2'b01;
    step();
    err4 = 2'b10;
    step();
    err4 = 2'b11;
    step();
    check("wrap_fill", 32'(fill4), 32'd3);
    check("wrap_h0_src",  32'(ev4_if.evSrc),  32'h1);
    check("wrap_h0_time", 32'(ev4_if.evTime), 32'd15);
    ev4_if.evReady = 1'b1;
    err4 = 2'b10;
    step();
    ev4_if.evReady = 1'b0;
    check("wrap_h1_src",  32'(ev4_if.evSrc),  32'h2);
    check("wrap_h1_time", 32'(ev4_if.evTime), 32'd0);
    check("wrap_h1_fill", 32'(fill4), 32'd2);
    err4 = 2'b11;
    step();
    check("wrap_pre_rst_fill", 32'(fill4), 32'd3);
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    check("midrst_valid", 32'(ev4_if.evValid), 32'd0);
    check("midrst_fill",  32'(fill4),          32'd0);
    check("midrst_drop",  32'(drop4),          32'd0);
    step();
    check("postrst_valid", 32'(ev4_if.evValid), 32'd1);
    check("postrst_src",   32'(ev4_if.evSrc),   32'h3);
    check("postrst_time",  32'(ev4_if.evTime),  32'd0);
    check("postrst_fill",  32'(fill4),          32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
